// File: rtl/sd_pkg.sv
// Shared constants for the serial pattern detector family: FSM state codes
// and the default pattern used by both the standalone detector and the stream controller.
package sd_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int                 SD_PLEN    = 4;
    localparam logic [SD_PLEN-1:0] SD_PATTERN = 4'b1101;

endpackage

// File: rtl/sd_match_core.sv
// Bit-serial pattern matcher: keeps the last PLEN-1 bits plus a fill count and
// flags a hit combinationally in the cycle the completing bit is presented.
module sd_match_core
    import sd_pkg::*;
#(
    parameter int              PLEN    = SD_PLEN,
    parameter logic [PLEN-1:0] PATTERN = SD_PATTERN,
    parameter bit              OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic bit_en,
    input  logic clr,
    output logic hit
);

    localparam int FW = $clog2(PLEN);

    logic [PLEN-2:0] hist;
    logic [FW-1:0]   fill;
    logic [PLEN-1:0] window;
    logic            full;

    // fill keeps the cleared zeros in hist from matching an all-zero pattern
    assign window = {hist, bit_in};
    assign full   = (fill == FW'(PLEN - 1));
    assign hit    = bit_en && full && (window == PATTERN);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (bit_en) begin
            if (hit && !OVERLAP) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= window[PLEN-2:0];
                if (!full) fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_stream_ctrl.sv
// Streaming front end for the pattern matcher: takes W-bit words, feeds them
// MSB-first one bit per clock, and reports per-word and running hit counts.
module sd_stream_ctrl
    import sd_pkg::*;
#(
    parameter int              W       = 8,
    parameter int              PLEN    = SD_PLEN,
    parameter logic [PLEN-1:0] PATTERN = SD_PATTERN,
    parameter bit              OVERLAP = 1'b1,
    parameter int              CW      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic                   flush,
    input  logic                   clr_cnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(W+1)-1:0] out_hits,
    output logic [CW-1:0]          out_total,
    output logic                   os,
    output logic [1:0]             rs
);

    localparam int HW = $clog2(W + 1);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [W-1:0]  word;
    logic [IW-1:0] idx;
    logic [HW-1:0] hits;
    logic          bit_en;
    logic          hit;
    logic          accept;
    logic          last_bit;

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // source holds valid/data until then, and ready never depends on valid.
    assign accept   = in_valid && in_ready;
    assign last_bit = (idx == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)  state_nxt = S_SHIFT;
            S_SHIFT: if (last_bit)  state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        bit_en    = (state == S_SHIFT);
        rs        = state;
    end

    // flush is gated by in_ready so it can only land between words
    sd_match_core #(
        .PLEN    (PLEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .bit_in (word[idx]),
        .bit_en (bit_en),
        .clr    (flush && in_ready),
        .hit    (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            idx  <= '0;
            hits <= '0;
        end else if (accept) begin
            word <= in_data;
            idx  <= IW'(W - 1);
            hits <= '0;
        end else if (bit_en) begin
            if (!last_bit) idx  <= idx - 1'b1;
            if (hit)       hits <= hits + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt)
            out_total <= '0;
        else if (hit && (out_total != {CW{1'b1}}))
            out_total <= out_total + 1'b1;
    end

    assign out_hits = hits;
    assign os       = hit;

endmodule

// File: tb/tb_sd_stream_ctrl.sv
// Directed bench for sd_stream_ctrl: three instances (default, OVERLAP=0, CW=2)
// share one stimulus stream; per-word results come from a hand-computed table.
module tb_sd_stream_ctrl;
    import sd_pkg::*;

    localparam int W  = 8;
    localparam int HW = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         flush;
    logic         clr_cnt;
    logic         out_ready;

    logic          a_in_ready, a_out_valid, a_os;
    logic [HW-1:0] a_out_hits;
    logic [15:0]   a_out_total;
    logic [1:0]    a_rs;
    logic          b_in_ready, b_out_valid, b_os;
    logic [HW-1:0] b_out_hits;
    logic [15:0]   b_out_total;
    logic [1:0]    b_rs;
    logic          c_in_ready, c_out_valid, c_os;
    logic [HW-1:0] c_out_hits;
    logic [1:0]    c_out_total;
    logic [1:0]    c_rs;

    typedef struct {
        logic [W-1:0] data;
        int           fmode;   // 0 none, 1 flush pulse in IDLE, 2 flush with accept, 3 flush during SHIFT
        bit           rst_before;
        int           h1;      // hits, OVERLAP=1
        int           h0;      // hits, OVERLAP=0
        int           t1;      // total, default
        int           t0;      // total, OVERLAP=0
        int           t2;      // total, CW=2
        logic [W-1:0] mask;    // os per fed bit, bit i = i-th fed bit
    } vec_t;

    vec_t          vecs[14];
    logic [HW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    sd_stream_ctrl #(.W(W), .OVERLAP(1'b1), .CW(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .flush(flush), .clr_cnt(clr_cnt), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_hits(a_out_hits), .out_total(a_out_total), .os(a_os), .rs(a_rs)
    );

    sd_stream_ctrl #(.W(W), .OVERLAP(1'b0), .CW(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .flush(flush), .clr_cnt(clr_cnt), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_hits(b_out_hits), .out_total(b_out_total), .os(b_os), .rs(b_rs)
    );

    sd_stream_ctrl #(.W(W), .OVERLAP(1'b1), .CW(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .flush(flush), .clr_cnt(clr_cnt), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_hits(c_out_hits), .out_total(c_out_total), .os(c_os), .rs(c_rs)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        clr_cnt   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Sends one word with out_ready=1 and checks the whole result cycle.
    task automatic send_word(input vec_t v, input string tag);
        logic [W-1:0]  mask;
        logic [HW-1:0] exp_h;
        int            b_cnt;
        bit            bad_state;
        if (v.rst_before) do_reset();
        if (v.fmode == 1) begin
            @(negedge clk);
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
        @(negedge clk);
        check({tag, " in_ready_idle"}, a_in_ready, 1);
        in_data  = v.data;
        in_valid = 1'b1;
        flush    = (v.fmode == 2);
        exp_q.push_back(HW'(v.h1));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = (v.fmode == 3);
        mask      = '0;
        b_cnt     = 0;
        bad_state = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (a_rs !== S_SHIFT || a_in_ready !== 1'b0 || a_out_valid !== 1'b0) bad_state = 1'b1;
            mask[i] = a_os;
            if (b_os === 1'b1) b_cnt++;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        check({tag, " shift_phase"}, bad_state, 0);
        @(negedge clk);
        check({tag, " out_valid"}, a_out_valid, 1);
        check({tag, " rs_done"}, a_rs, S_DONE);
        check({tag, " sb_nonempty"}, exp_q.size() > 0, 1);
        exp_h = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, " hits_ovl1"}, a_out_hits, exp_h);
        check({tag, " hits_ovl0"}, b_out_hits, v.h0);
        check({tag, " hits_cw2"}, c_out_hits, v.h1);
        check({tag, " total_ovl1"}, a_out_total, v.t1);
        check({tag, " total_ovl0"}, b_out_total, v.t0);
        check({tag, " total_cw2"}, c_out_total, v.t2);
        check({tag, " os_mask"}, mask, v.mask);
        check({tag, " os_count_ovl0"}, b_cnt, v.h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, " rs_idle_after"}, a_rs, S_IDLE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        clr_cnt   = 1'b0;
        out_ready = 1'b1;

        //          data   fm rst h1 h0 t1 t0 t2 mask
        vecs[0]  = '{8'hD0, 0, 1'b0, 1, 1, 1, 1, 1, 8'h08};
        vecs[1]  = '{8'hDA, 0, 1'b0, 2, 1, 3, 2, 3, 8'h48};
        vecs[2]  = '{8'h03, 0, 1'b0, 0, 0, 3, 2, 3, 8'h00};
        vecs[3]  = '{8'h40, 0, 1'b0, 1, 1, 4, 3, 3, 8'h02};
        vecs[4]  = '{8'h03, 0, 1'b0, 0, 0, 4, 3, 3, 8'h00};
        vecs[5]  = '{8'h40, 1, 1'b0, 0, 0, 4, 3, 3, 8'h00};
        vecs[6]  = '{8'h03, 0, 1'b0, 0, 0, 4, 3, 3, 8'h00};
        vecs[7]  = '{8'h40, 2, 1'b0, 0, 0, 4, 3, 3, 8'h00};
        vecs[8]  = '{8'h03, 3, 1'b0, 0, 0, 4, 3, 3, 8'h00};
        vecs[9]  = '{8'h40, 0, 1'b0, 1, 1, 5, 4, 3, 8'h02};
        vecs[10] = '{8'hD0, 0, 1'b1, 1, 1, 1, 1, 1, 8'h08};
        vecs[11] = '{8'hD0, 0, 1'b0, 1, 1, 2, 2, 2, 8'h08};
        vecs[12] = '{8'hD0, 0, 1'b0, 1, 1, 3, 3, 3, 8'h08};
        vecs[13] = '{8'hD0, 0, 1'b0, 1, 1, 4, 4, 3, 8'h08};

        do_reset();
        @(negedge clk);
        check("reset rs", a_rs, S_IDLE);
        check("reset in_ready", a_in_ready, 1);
        check("reset out_valid", a_out_valid, 0);
        check("reset out_hits", a_out_hits, 0);
        check("reset out_total", a_out_total, 0);
        check("reset os", a_os, 0);

        for (int i = 0; i < 14; i++) send_word(vecs[i], $sformatf("vec%0d", i));

        // Reset in the third SHIFT cycle, which is also a hit cycle.
        send_word('{8'h03, 0, 1'b0, 0, 0, 4, 4, 3, 8'h00}, "pre_abort");
        in_data  = 8'hA0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("abort os_before", a_os, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort rs", a_rs, S_IDLE);
        check("abort in_ready", a_in_ready, 1);
        check("abort out_valid", a_out_valid, 0);
        check("abort out_hits", a_out_hits, 0);
        check("abort total_ovl1", a_out_total, 0);
        check("abort total_ovl0", b_out_total, 0);
        check("abort total_cw2", c_out_total, 0);
        check("abort os", {a_os, b_os, c_os}, 0);
        send_word('{8'h40, 0, 1'b0, 0, 0, 0, 0, 0, 8'h00}, "post_abort");

        // Back-pressure in DONE with in_valid held high throughout.
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        in_data  = 8'hD0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_data = 8'h00;
        repeat (W) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d out_valid", k), a_out_valid, 1);
            check($sformatf("stall%0d out_hits", k), a_out_hits, 1);
            check($sformatf("stall%0d in_ready", k), a_in_ready, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        check("stall release out_valid", a_out_valid, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_hs rs", a_rs, S_IDLE);
        check("after_hs in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("next_accept rs", a_rs, S_SHIFT);
        in_valid = 1'b0;
        repeat (W) @(posedge clk);
        @(negedge clk);
        check("next_word out_valid", a_out_valid, 1);
        check("next_word out_hits", a_out_hits, 0);
        check("next_word total", a_out_total, 1);
        @(posedge clk);
        #1;

        // clr_cnt in the same cycle as a hit: clear wins, out_hits untouched.
        do_reset();
        @(negedge clk);
        in_data  = 8'hD0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            clr_cnt = (i == 3);
            if (i == 3) check("clr os_at_hit", a_os, 1);
            @(posedge clk);
            #1;
        end
        clr_cnt = 1'b0;
        @(negedge clk);
        check("clr out_valid", a_out_valid, 1);
        check("clr out_hits", a_out_hits, 1);
        check("clr total_ovl1", a_out_total, 0);
        check("clr total_cw2", c_out_total, 0);
        @(posedge clk);
        #1;

        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
